// File: rtl/fp_mul_scheduler_pkg.sv
// fp_mul_sched_pkg: shared types, defaults and helpers for the multiplier scheduler
package fp_mul_sched_pkg;
  localparam int MUL_LAT_DEF = 2;
  localparam int ID_W_MAX = 3;
  typedef struct packed {
    logic valid;
    logic [ID_W_MAX-1:0] id;
  } sched_tag_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction
endpackage

// File: rtl/fp_mul_scheduler_if.sv
// fp_mul_scheduler_if: requester-side request/response bundle of the scheduler
interface fp_mul_scheduler_if import fp_mul_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int N = 32
) ();
  localparam int IDW = clog2(NREQ);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [N-1:0] rsp_result;
  logic rsp_overflow;
  modport master (output req_valid, req_a, req_b,
                  input req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow);
  modport slave (input req_valid, req_a, req_b,
                 output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow);
endinterface

// File: rtl/fp_mul_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from rr_ptr with wrap
module rr_arbiter import fp_mul_sched_pkg::*; #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [clog2(NREQ)-1:0] rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [clog2(NREQ)-1:0] winner,
  output logic any_grant
);
  localparam int IDW = clog2(NREQ);
  logic [2*NREQ-1:0] rot;
  always_comb begin
    rot = {eligible, eligible} >> rr_ptr;
    winner = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) winner = IDW'((int'(rr_ptr) + k) % NREQ);
    any_grant = |eligible;
    grant = any_grant ? NREQ'(1) << winner : '0;
  end
endmodule

// File: rtl/fp_mul_scheduler.sv
// fp_mul_scheduler: shares one pipelined multiplier among NREQ requesters, routing results by tag
module fp_mul_scheduler import fp_mul_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int N = 32,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int MAX_OUT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  fp_mul_scheduler_if.slave rq,
  output logic mul_enable,
  output logic mul_reset,
  output logic [N-1:0] mul_a,
  output logic [N-1:0] mul_b,
  input  logic [N-1:0] mul_result,
  input  logic mul_overflow,
  output logic idle,
  output logic [31:0] op_count,
  output logic [15:0] ovf_count
);
  localparam int IDW = clog2(NREQ);
  localparam int CW = clog2(MAX_OUT + 1);
  sched_tag_t tag_pipe [MUL_LAT];
  logic [CW-1:0] out_cnt [NREQ];
  logic [IDW-1:0] rr_ptr, winner;
  logic [NREQ-1:0] eligible, grant, ret;
  logic any_grant;
  assign mul_enable = 1'b1;
  assign mul_reset = reset;
  assign rq.rsp_valid = tag_pipe[MUL_LAT-1].valid & ~reset;
  assign rq.rsp_id = tag_pipe[MUL_LAT-1].id[IDW-1:0];
  assign rq.rsp_result = mul_result;
  assign rq.rsp_overflow = mul_overflow;
  assign rq.req_ready = grant;
  assign ret = rq.rsp_valid ? NREQ'(1) << rq.rsp_id : '0;
  assign mul_a = any_grant ? rq.req_a[winner*N +: N] : '0;
  assign mul_b = any_grant ? rq.req_b[winner*N +: N] : '0;
  // A slot freed by this cycle's response can be reused at once, giving MAX_OUT issues per MUL_LAT
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++)
      eligible[i] = rq.req_valid[i] & ~hold & ~reset & ((out_cnt[i] - CW'(ret[i])) < CW'(MAX_OUT));
  end
  always_comb begin
    idle = ~|rq.req_valid;
    for (int i = 0; i < MUL_LAT; i++)
      if (tag_pipe[i].valid) idle = 1'b0;
  end
  rr_arbiter #(.NREQ(NREQ)) arb (
    .eligible(eligible),
    .rr_ptr(rr_ptr),
    .grant(grant),
    .winner(winner),
    .any_grant(any_grant)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) tag_pipe[i] <= '0;
      for (int i = 0; i < NREQ; i++) out_cnt[i] <= '0;
      rr_ptr <= '0;
      op_count <= '0;
      ovf_count <= '0;
    end else begin
      tag_pipe[0] <= '{valid: any_grant, id: ID_W_MAX'(winner)};
      for (int i = 1; i < MUL_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      for (int i = 0; i < NREQ; i++) out_cnt[i] <= out_cnt[i] + CW'(grant[i]) - CW'(ret[i]);
      if (any_grant) begin
        rr_ptr <= (int'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);
        op_count <= op_count + 32'd1;
      end
      if (rq.rsp_valid && rq.rsp_overflow && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
    end
  end
endmodule
